// File: rtl/fun_sweep_ctrl_pkg.sv
// Shared types and constants for the function-block sweep sequencer.
package fun_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int VEC_COUNT = 16;
  localparam int IDX_W     = 4;

endpackage

// File: rtl/fun_sweep_ctrl_settle.sv
// Settle timer: loadable up-counter with a terminal-count flag that fires
// on the last cycle of the settle window.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // load wins over count so a fresh vector always starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/fun_sweep_ctrl.sv
// Sweeps a dual-rail 4-input function block through all 16 vectors,
// captures its truth table and compares it against a golden table.
module fun_sweep_ctrl
  import fun_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VEC_COUNT-1:0] expected_tt,
  input  logic                 fun_out,
  output logic                 a,
  output logic                 not_a,
  output logic                 b,
  output logic                 not_b,
  output logic                 c,
  output logic                 not_c,
  output logic                 d,
  output logic                 not_d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [VEC_COUNT-1:0] truth_table,
  output logic [4:0]           err_count
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [VEC_COUNT-1:0] exp_q, exp_d;
  logic [VEC_COUNT-1:0] tt_q, tt_d;
  logic [4:0]           err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 tmr_load, tmr_en, tmr_tc;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  // next-state and next-output logic; err_d already includes the current
  // sample so DONE always sees the final count
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d  = SETTLE;
          exp_d    = expected_tt;
          tt_d     = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[idx_q] = fun_out;
        if (fun_out != exp_q[idx_q]) err_d = err_q + 5'd1;
        if (idx_q == IDX_W'(VEC_COUNT - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 5'd0);
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // both rails come straight off the idx register, so they switch together
  // and can never show a 0/0 or 1/1 pair
  assign a     = idx_q[3];
  assign b     = idx_q[2];
  assign c     = idx_q[1];
  assign d     = idx_q[0];
  assign not_a = ~idx_q[3];
  assign not_b = ~idx_q[2];
  assign not_c = ~idx_q[1];
  assign not_d = ~idx_q[0];

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign truth_table = tt_q;
  assign err_count   = err_q;

endmodule
